// File: rtl/comparador_pkg.sv
// Shared types and constants for the bit-serial comparator sequencer.
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARA   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  localparam int WIDTH_DEF = 4;

  // Counter must hold values 0..w, hence w+1 codes.
  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/a_mayor_b.sv
// One-bit magnitude compare cell: out flags a>b, hab_out keeps the chain enabled on equal bits.
module a_mayor_b (
  input  logic hab_in,
  input  logic a,
  input  logic b,
  output logic out,
  output logic hab_out
);

  assign out     = hab_in & a & ~b;
  assign hab_out = hab_in & ~(a ^ b);

endmodule

// File: rtl/comparador_serie_ctrl.sv
// Bit-serial A/B comparator: walks one a_mayor_b cell MSB-first and stops at the first differing bit.
module comparador_serie_ctrl
  import comparador_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = calc_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_mayor,
  output logic             a_menor,
  output logic             iguales,
  output logic [CW-1:0]    ciclos
);

  localparam int IW = $clog2(WIDTH);

  estado_t          state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             a_mayor_q, a_mayor_d;
  logic             a_menor_q, a_menor_d;
  logic             iguales_q, iguales_d;
  logic             out_valid_q, out_valid_d;
  logic [CW-1:0]    ciclos_q, ciclos_d;

  logic hab_s, bit_a_s, bit_b_s, cell_out_s, cell_hab_out_s;

  assign hab_s   = (state_q == COMPARA);
  assign bit_a_s = a_q[idx_q];
  assign bit_b_s = b_q[idx_q];

  a_mayor_b u_celda (
    .hab_in  (hab_s),
    .a       (bit_a_s),
    .b       (bit_b_s),
    .out     (cell_out_s),
    .hab_out (cell_hab_out_s)
  );

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    a_mayor_d   = a_mayor_q;
    a_menor_d   = a_menor_q;
    iguales_d   = iguales_q;
    out_valid_d = out_valid_q;
    ciclos_d    = ciclos_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          idx_d     = IW'(WIDTH - 1);
          a_mayor_d = 1'b0;
          a_menor_d = 1'b0;
          iguales_d = 1'b0;
          ciclos_d  = {CW{1'b0}};
          state_d   = COMPARA;
        end else begin
          state_d = IDLE;
        end
      end
      COMPARA: begin
        ciclos_d = ciclos_q + CW'(1);
        // With hab_in high, hab_out low means this bit decides; out tells which way.
        if (!cell_hab_out_s) begin
          a_mayor_d   = cell_out_s;
          a_menor_d   = ~cell_out_s;
          out_valid_d = 1'b1;
          state_d     = RESULTADO;
        end else if (idx_q == {IW{1'b0}}) begin
          iguales_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = RESULTADO;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      RESULTADO: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESULTADO;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= IW'(WIDTH - 1);
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      a_mayor_q   <= 1'b0;
      a_menor_q   <= 1'b0;
      iguales_q   <= 1'b0;
      out_valid_q <= 1'b0;
      ciclos_q    <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_mayor_q   <= a_mayor_d;
      a_menor_q   <= a_menor_d;
      iguales_q   <= iguales_d;
      out_valid_q <= out_valid_d;
      ciclos_q    <= ciclos_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign a_mayor   = a_mayor_q;
  assign a_menor   = a_menor_q;
  assign iguales   = iguales_q;
  assign ciclos    = ciclos_q;

endmodule
